seg_scroll_ctrl: RTL and testbench

Sequencer that owns the two-digit symbol path into SegDecoder. It accepts a short message of 2-bit symbols over a valid/ready write port into a local buffer. It then scrolls through the message at a prescaled rate, presenting each adjacent symbol pair on io_data1/io_data2, which are wired directly to the decoder inputs. It sits between the application logic (message source, run/clear controls) and SegDecoder.

---
 rtl/seg_scroll_ctrl.sv | 148 ++++++++++++++
 tb/tb_seg_scroll_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scroll_ctrl.sv
// Message buffer and scroll sequencer feeding the two-digit SegDecoder.
// Symbols are loaded over a valid/ready port, then shown pairwise at a prescaled rate.
module seg_scroll_ctrl #(
    parameter int CLK_DIV = 12000000,
    parameter int DEPTH   = 8,
    parameter int DW      = 2
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          io_wr_valid,
    output logic          io_wr_ready,
    input  logic [DW-1:0] io_wr_data,
    input  logic          io_wr_last,
    input  logic          io_run,
    input  logic          io_clear,
    output logic [DW-1:0] io_data1,
    output logic [DW-1:0] io_data2,
    output logic          io_blank,
    output logic          io_wrap
);

    localparam int PW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t          state_r;
    logic [PW-1:0]   len_r;
    logic [PW-1:0]   wptr_r;
    logic [PW-1:0]   ptr_r;
    logic [CW-1:0]   presc_r;
    logic            wrap_r;
    logic [DW-1:0]   mem_r [DEPTH];

    logic            wr_fire_s;
    logic            mem_we_s;
    logic [AW-1:0]   mem_waddr_s;
    logic [PW-1:0]   len_inc_s;
    logic            ptr_last_s;
    logic [PW-1:0]   ptr_nxt_s;
    logic            tick_s;
    logic [DW-1:0]   data1_s;
    logic [DW-1:0]   data2_s;

    assign io_wr_ready = reset_n && (state_r != ST_SHOW);
    assign wr_fire_s   = io_wr_valid && io_wr_ready;
    assign len_inc_s   = len_r + PW'(1);
    assign ptr_last_s  = (ptr_r == (len_r - PW'(1)));
    assign ptr_nxt_s   = ptr_last_s ? PW'(0) : (ptr_r + PW'(1));
    assign tick_s      = io_run && (presc_r == CW'(CLK_DIV - 1));

    // Buffer write enable and address; a write colliding with clear is dropped.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = AW'(0);
        if (wr_fire_s && !io_clear) begin
            mem_we_s    = (state_r == ST_EMPTY) || (state_r == ST_LOAD);
            mem_waddr_s = (state_r == ST_EMPTY) ? AW'(0) : wptr_r[AW-1:0];
        end else begin
            mem_we_s    = 1'b0;
            mem_waddr_s = AW'(0);
        end
    end

    // Symbol storage; contents are don't-care until a message is loaded.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= io_wr_data;
        end
    end

    // Control FSM: load, scroll prescaler, pointer and wrap pulse.
    always_ff @(posedge clock) begin
        if (!reset_n || io_clear) begin
            state_r <= ST_EMPTY;
            len_r   <= PW'(0);
            wptr_r  <= PW'(0);
            ptr_r   <= PW'(0);
            presc_r <= CW'(0);
            wrap_r  <= 1'b0;
        end else begin
            wrap_r <= 1'b0;
            case (state_r)
                ST_EMPTY: begin
                    if (wr_fire_s) begin
                        len_r   <= PW'(1);
                        wptr_r  <= PW'(1);
                        ptr_r   <= PW'(0);
                        presc_r <= CW'(0);
                        state_r <= io_wr_last ? ST_SHOW : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (wr_fire_s) begin
                        len_r  <= len_inc_s;
                        wptr_r <= wptr_r + PW'(1);
                        // A full buffer ends the message even without last.
                        if (io_wr_last || (len_inc_s == PW'(DEPTH))) begin
                            ptr_r   <= PW'(0);
                            presc_r <= CW'(0);
                            state_r <= ST_SHOW;
                        end
                    end
                end
                ST_SHOW: begin
                    if (tick_s) begin
                        presc_r <= CW'(0);
                        ptr_r   <= ptr_nxt_s;
                        wrap_r  <= ptr_last_s;
                    end else if (io_run) begin
                        presc_r <= presc_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                    len_r   <= PW'(0);
                    wptr_r  <= PW'(0);
                    ptr_r   <= PW'(0);
                    presc_r <= CW'(0);
                end
            endcase
        end
    end

    // Current pair straight from the pointer registers; dark unless showing.
    always_comb begin
        data1_s = DW'(0);
        data2_s = DW'(0);
        if (state_r == ST_SHOW) begin
            data1_s = mem_r[ptr_r[AW-1:0]];
            data2_s = mem_r[ptr_nxt_s[AW-1:0]];
        end else begin
            data1_s = DW'(0);
            data2_s = DW'(0);
        end
    end

    assign io_data1 = data1_s;
    assign io_data2 = data2_s;
    assign io_blank = (state_r != ST_SHOW);
    assign io_wrap  = wrap_r;

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// Directed bench for seg_scroll_ctrl with CLK_DIV=4, DEPTH=8.
module tb_seg_scroll_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       io_wr_valid;
    logic       io_wr_ready;
    logic [1:0] io_wr_data;
    logic       io_wr_last;
    logic       io_run;
    logic       io_clear;
    logic [1:0] io_data1;
    logic [1:0] io_data2;
    logic       io_blank;
    logic       io_wrap;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       valid;
        logic [1:0] data;
        logic       last;
        logic       run;
        logic       clear;
        logic       exp_ready;
        logic       exp_blank;
        logic [1:0] exp_d1;
        logic [1:0] exp_d2;
        logic       exp_wrap;
    } vec_t;

    vec_t tbl [27];

    seg_scroll_ctrl #(.CLK_DIV(4), .DEPTH(8), .DW(2)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .io_wr_valid (io_wr_valid),
        .io_wr_ready (io_wr_ready),
        .io_wr_data  (io_wr_data),
        .io_wr_last  (io_wr_last),
        .io_run      (io_run),
        .io_clear    (io_clear),
        .io_data1    (io_data1),
        .io_data2    (io_data2),
        .io_blank    (io_blank),
        .io_wrap     (io_wrap)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] d, input logic l,
                         input logic r, input logic c);
        io_wr_valid = v;
        io_wr_data  = d;
        io_wr_last  = l;
        io_run      = r;
        io_clear    = c;
    endtask

    task automatic chk1(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic rdy, input logic blank,
                           input logic [1:0] d1, input logic [1:0] d2, input logic wrap);
        chk1({name, ".ready"}, {1'b0, io_wr_ready}, {1'b0, rdy});
        chk1({name, ".blank"}, {1'b0, io_blank}, {1'b0, blank});
        chk1({name, ".data1"}, io_data1, d1);
        chk1({name, ".data2"}, io_data2, d2);
        chk1({name, ".wrap"},  {1'b0, io_wrap}, {1'b0, wrap});
    endtask

    initial begin
        // Load {1,2,3}, scroll one full lap, then clear.
        tbl[0]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0};
        tbl[1]  = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0};
        tbl[2]  = '{1'b1, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 1'b0};
        tbl[3]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 1'b0};
        tbl[4]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 1'b0};
        tbl[5]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 1'b0};
        tbl[6]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd3, 1'b0};
        tbl[7]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd3, 1'b0};
        tbl[8]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd3, 1'b0};
        tbl[9]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd3, 1'b0};
        tbl[10] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 2'd1, 1'b0};
        tbl[11] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 2'd1, 1'b0};
        tbl[12] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 2'd1, 1'b0};
        tbl[13] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 2'd1, 1'b0};
        tbl[14] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 1'b1};
        tbl[15] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 1'b0};
        tbl[16] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0};
        // Overflow: 10 symbols streamed without last, run held low.
        tbl[17] = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0};
        tbl[18] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0};
        tbl[19] = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0};
        tbl[20] = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0};
        tbl[21] = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0};
        tbl[22] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0};
        tbl[23] = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0};
        tbl[24] = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0};
        tbl[25] = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0};
        tbl[26] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0};

        // Reset held with a pending write.
        reset_n = 1'b0;
        drive(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
        step();
        step();
        step();
        chk_all("reset", 1'b0, 1'b1, 2'd0, 2'd0, 1'b0);
        reset_n     = 1'b1;
        io_wr_valid = 1'b0;
        #1;
        chk1("reset_release.ready", {1'b0, io_wr_ready}, 2'd1);

        for (int i = 0; i < 27; i++) begin
            drive(tbl[i].valid, tbl[i].data, tbl[i].last, tbl[i].run, tbl[i].clear);
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].exp_ready, tbl[i].exp_blank,
                    tbl[i].exp_d1, tbl[i].exp_d2, tbl[i].exp_wrap);
        end

        // Pause at prescaler=2 on the 8-symbol message 0,1,2,3,0,1,2,3.
        drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        step();
        step();
        chk_all("pause_pre", 1'b0, 1'b0, 2'd0, 2'd1, 1'b0);
        io_run = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk_all($sformatf("pause_hold%0d", k), 1'b0, 1'b0, 2'd0, 2'd1, 1'b0);
        end
        io_run = 1'b1;
        step();
        chk_all("resume1", 1'b0, 1'b0, 2'd0, 2'd1, 1'b0);
        step();
        chk_all("resume2", 1'b0, 1'b0, 2'd1, 2'd2, 1'b0);

        // Walk to the last entry, proving len=8, then wrap.
        for (int k = 0; k < 24; k++) begin
            step();
            chk1($sformatf("walk%0d.wrap", k), {1'b0, io_wrap}, 2'd0);
        end
        chk_all("ptr7", 1'b0, 1'b0, 2'd3, 2'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk1($sformatf("prewrap%0d.wrap", k), {1'b0, io_wrap}, 2'd0);
        end
        step();
        chk_all("wrap8", 1'b0, 1'b0, 2'd0, 2'd1, 1'b1);
        step();
        chk_all("postwrap8", 1'b0, 1'b0, 2'd0, 2'd1, 1'b0);

        // Clear in the tick cycle.
        step();
        step();
        io_clear = 1'b1;
        step();
        chk_all("clear_tick", 1'b1, 1'b1, 2'd0, 2'd0, 1'b0);

        // Clear colliding with a LOAD write; next message starts at mem[0].
        drive(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("load_a", 1'b1, 1'b1, 2'd0, 2'd0, 1'b0);
        drive(1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
        step();
        chk_all("clear_write", 1'b1, 1'b1, 2'd0, 2'd0, 1'b0);
        drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("reload", 1'b0, 1'b0, 2'd1, 2'd0, 1'b0);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        step();
        chk_all("clear2", 1'b1, 1'b1, 2'd0, 2'd0, 1'b0);

        // Single symbol message: wrap pulse on every tick.
        drive(1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("single", 1'b0, 1'b0, 2'd2, 2'd2, 1'b0);
        drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk_all($sformatf("single%0d", k), 1'b0, 1'b0, 2'd2, 2'd2,
                    ((k % 4) == 3) ? 1'b1 : 1'b0);
        end
        step();
        step();
        step();
        io_clear = 1'b1;
        step();
        chk_all("clear_wraptick", 1'b1, 1'b1, 2'd0, 2'd0, 1'b0);
        io_clear = 1'b0;
        io_run   = 1'b0;
        step();
        chk_all("after_clear", 1'b1, 1'b1, 2'd0, 2'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
